// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the MEM-stage data-memory access controller.
// Holds the load/store func3 encodings, FSM state encodings and the
// access-size / misalignment helpers used by the lane formatter.
package dmem_pkg;

    // func3 encodings of the pipeline load/store instructions
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encodings (kept as plain constants for older tooling)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        DM_IDLE   = ST_IDLE,
        DM_ACCESS = ST_ACCESS,
        DM_DONE   = ST_DONE
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } dmem_size_t;

    // Access size from func3; the undefined codes behave as a word access.
    function automatic dmem_size_t dmem_size(input logic [2:0] f3);
        dmem_size_t sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // True when the low address bits are not a multiple of the access size.
    function automatic logic dmem_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
        logic mis;
        case (dmem_size(f3))
            SZ_HALF: mis = a_lo[0];
            SZ_WORD: mis = (a_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational byte-lane formatter.
// Store side: byte enables and lane-replicated write data.
// Load side: extracts the addressed byte/half and sign/zero-extends it.
// With DMEM_MISALIGN_TRAP_EN defined it also flags misaligned accesses;
// otherwise low address bits below the access size are simply ignored.
module dmem_lane_fmt
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_we,
    input  logic [2:0]        i_func3,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic              o_misaligned,
`endif
    output logic [DATA_W-1:0] o_rdata
);

    dmem_size_t w_size;
    logic       w_unsigned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_size     = dmem_size(i_func3);
    assign w_unsigned = i_func3[2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign o_misaligned = dmem_misaligned(i_func3, i_addr_lo);
`endif

    // store byte enables and replicated write lanes; loads enable all four bytes
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        if (i_we) begin
            case (w_size)
                SZ_BYTE: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                SZ_HALF: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
            endcase
        end else begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
        end
    end

    // pick the addressed lane of the read word and extend it to 32 bits
    always_comb begin
        w_byte  = 8'h00;
        o_rdata = i_rdata;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (w_size)
            SZ_BYTE: o_rdata = {{24{~w_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{~w_unsigned & w_half[15]}}, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage controller between the EX/MEM register and a
// single-port, variable-latency data RAM. Each load/store becomes one
// word-addressed bus transaction; the pipeline is stalled until it completes
// and the formatted load value is presented with a one-cycle rd_valid pulse.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (misaligned H/W accesses skip
// the bus and raise err instead of being forced aligned).
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  stall,
    output logic                  err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DM_ADDRESS-3:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ready,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    dmem_state_t           r_state;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [2:0]            r_func3;
    logic                  r_we;
    logic [TMR_W-1:0]      r_timer;
    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_rd_valid;
    logic                  r_err;

    logic                  w_idle;
    logic                  w_req;
    logic                  w_trap;
    logic                  w_fmt_we;
    logic [2:0]            w_fmt_func3;
    logic [1:0]            w_fmt_addr_lo;
    logic [DATA_W-1:0]     w_fmt_wdata_in;
    logic [3:0]            w_be;
    logic [DATA_W-1:0]     w_wdata_rep;
    logic [DATA_W-1:0]     w_load_data;

    assign w_idle = (r_state == DM_IDLE);
    assign w_req  = mem_read | mem_write;

    // In IDLE the formatter looks at the incoming request (for the misalign
    // check); once a transaction is running it only sees the latched copy.
    assign w_fmt_we       = w_idle ? mem_write   : r_we;
    assign w_fmt_func3    = w_idle ? func3       : r_func3;
    assign w_fmt_addr_lo  = w_idle ? addr[1:0]   : r_addr[1:0];
    assign w_fmt_wdata_in = w_idle ? wr_data     : r_wdata;

    dmem_lane_fmt #(
        .DATA_W       (DATA_W)
    ) u_lane_fmt (
        .i_we         (w_fmt_we),
        .i_func3      (w_fmt_func3),
        .i_addr_lo    (w_fmt_addr_lo),
        .i_wdata      (w_fmt_wdata_in),
        .i_rdata      (bus_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata_rep),
`ifdef DMEM_MISALIGN_TRAP_EN
        .o_misaligned (w_trap),
`endif
        .o_rdata      (w_load_data)
    );

`ifndef DMEM_MISALIGN_TRAP_EN
    assign w_trap = 1'b0;
`endif

    // request capture, bus wait with timeout, and the one-cycle completion state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= DM_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_func3    <= 3'b000;
            r_we       <= 1'b0;
            r_timer    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                DM_IDLE: begin
                    r_rd_valid <= 1'b0;
                    r_err      <= 1'b0;
                    if (w_req) begin
                        r_addr  <= addr;
                        r_wdata <= wr_data;
                        r_func3 <= func3;
                        r_we    <= mem_write;
                        r_timer <= '0;
                        if (w_trap) begin
                            // misaligned: skip the bus, report straight away
                            r_state    <= DM_DONE;
                            r_rd_data  <= '0;
                            r_err      <= 1'b1;
                            r_rd_valid <= ~mem_write;
                        end else begin
                            r_state <= DM_ACCESS;
                        end
                    end else begin
                        r_state <= DM_IDLE;
                    end
                end
                DM_ACCESS: begin
                    if (bus_ready) begin
                        r_state    <= DM_DONE;
                        r_rd_valid <= ~r_we;
                        if (!r_we) begin
                            r_rd_data <= w_load_data;
                        end else begin
                            r_rd_data <= r_rd_data;
                        end
                    end else if (r_timer == TMR_LAST) begin
                        // bus never answered: abandon the transaction
                        r_state    <= DM_DONE;
                        r_rd_data  <= '0;
                        r_err      <= 1'b1;
                        r_rd_valid <= ~r_we;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DM_DONE: begin
                    // the held request is not re-accepted: always back to IDLE
                    r_state    <= DM_IDLE;
                    r_rd_valid <= 1'b0;
                    r_err      <= 1'b0;
                end
                default: begin
                    r_state    <= DM_IDLE;
                    r_rd_valid <= 1'b0;
                    r_err      <= 1'b0;
                end
            endcase
        end
    end

    // pipeline freeze: immediate on a new request, held for the whole bus wait
    always_comb begin
        stall = 1'b0;
        case (r_state)
            DM_IDLE:   stall = w_req;
            DM_ACCESS: stall = 1'b1;
            DM_DONE:   stall = 1'b0;
            default:   stall = 1'b0;
        endcase
    end

    assign bus_req   = (r_state == DM_ACCESS);
    assign bus_we    = bus_req & r_we;
    assign bus_addr  = bus_req ? r_addr[DM_ADDRESS-1:2] : '0;
    assign bus_be    = bus_req ? w_be : 4'b0000;
    assign bus_wdata = (bus_req & r_we) ? w_wdata_rep : '0;

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;

endmodule
